// File: rtl/tag_tx_ctrl_tag_chip_nb.sv
// Anchor-side narrowband TX controller: GPIO sync preamble, hop control and BPSK I/Q per hop.
// Optional PN9 payload whitening is enabled with the TAG_TX_WHITEN_EN macro.
module tag_tx_ctrl_tag_chip_nb #(
    parameter int DATA_WIDTH     = 16,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int NUM_HOPS       = 8,
    parameter int BITS_PER_HOP   = 16,
    parameter int SAMPS_PER_BIT  = 64,
    parameter int SYNC_SIG_N     = 8192,
    parameter int AMP            = 16000,
    parameter int BIT_CNT_WIDTH  = 7
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_HOPS*BITS_PER_HOP-1:0]    payload_in,
    input  logic                                payload_valid,
    output logic                                payload_ready,
    input  logic [GPIO_REG_WIDTH-1:0]           fp_gpio_in,
    output logic [GPIO_REG_WIDTH-1:0]           fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0]           fp_gpio_ddr,
    output logic [DATA_WIDTH-1:0]               itx_out,
    output logic [DATA_WIDTH-1:0]               qtx_out,
    output logic                                tx_valid,
    output logic [2:0]                          tx_state,
    output logic                                hop_rst,
    output logic                                hop_clk,
    output logic [BIT_CNT_WIDTH-1:0]            nhop,
    output logic [BIT_CNT_WIDTH-1:0]            ntx_bits_cnt,
    output logic                                tx_done
);

    localparam int TOTAL  = NUM_HOPS * BITS_PER_HOP;
    localparam int SAMP_W = (SAMPS_PER_BIT > 1) ? $clog2(SAMPS_PER_BIT) : 1;
    localparam int SYNC_W = (SYNC_SIG_N > 1) ? $clog2(SYNC_SIG_N) : 1;
    localparam logic [DATA_WIDTH-1:0] AMP_POS = DATA_WIDTH'(AMP);
    localparam logic [DATA_WIDTH-1:0] AMP_NEG = DATA_WIDTH'(-AMP);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_SYNC     = 3'd2,
        S_HOP      = 3'd3,
        S_DATA     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                    state_reg;
    logic [TOTAL-1:0]          payload_reg;
    logic [SYNC_W-1:0]         sync_cnt_reg;
    logic [SAMP_W-1:0]         samp_cnt_reg;
    logic [BIT_CNT_WIDTH-1:0]  nhop_reg;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_reg;
    logic [DATA_WIDTH-1:0]     itx_reg;
    logic                      tx_valid_reg;
    logic                      sync_reg;
    logic                      hop_rst_reg;
    logic                      hop_clk_reg;
    logic                      tx_bit_reg;
    logic                      tx_done_reg;
    logic                      ready_reg;
    logic [GPIO_REG_WIDTH-1:0] ddr_reg;

    logic tag_en;
    logic tag_rdy;
    logic abort;
    logic first_bit;
    logic next_bit;
    logic gpio_unused;

    assign tag_en      = fp_gpio_in[5];
    assign tag_rdy     = fp_gpio_in[1];
    assign gpio_unused = ^fp_gpio_in;
    assign abort       = !tag_en && (state_reg == S_WAIT_RDY || state_reg == S_SYNC ||
                                     state_reg == S_HOP || state_reg == S_DATA);

    // The payload shifts left once per bit, so the bit on air is always near the MSB.
`ifdef TAG_TX_WHITEN_EN
    logic [8:0] lfsr_reg;
    assign first_bit = payload_reg[TOTAL-1] ^ lfsr_reg[8];
    assign next_bit  = payload_reg[TOTAL-2] ^ lfsr_reg[7];
`else
    assign first_bit = payload_reg[TOTAL-1];
    assign next_bit  = payload_reg[TOTAL-2];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            payload_reg  <= '0;
            sync_cnt_reg <= '0;
            samp_cnt_reg <= '0;
            nhop_reg     <= '0;
            bit_cnt_reg  <= '0;
            itx_reg      <= '0;
            tx_valid_reg <= 1'b0;
            sync_reg     <= 1'b0;
            hop_rst_reg  <= 1'b0;
            hop_clk_reg  <= 1'b0;
            tx_bit_reg   <= 1'b0;
            tx_done_reg  <= 1'b0;
            ready_reg    <= 1'b0;
            ddr_reg      <= GPIO_REG_WIDTH'(12'hF00);
`ifdef TAG_TX_WHITEN_EN
            lfsr_reg     <= '0;
`endif
        end else begin
            ddr_reg     <= GPIO_REG_WIDTH'(12'hF00);
            tx_done_reg <= 1'b0;
            hop_clk_reg <= 1'b0;
            if (abort) begin
                state_reg    <= S_IDLE;
                payload_reg  <= '0;
                sync_cnt_reg <= '0;
                samp_cnt_reg <= '0;
                nhop_reg     <= '0;
                bit_cnt_reg  <= '0;
                itx_reg      <= '0;
                tx_valid_reg <= 1'b0;
                sync_reg     <= 1'b0;
                hop_rst_reg  <= 1'b0;
                tx_bit_reg   <= 1'b0;
                ready_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        ready_reg <= tag_en;
                        if (payload_valid && ready_reg && tag_en) begin
                            payload_reg <= payload_in;
                            ready_reg   <= 1'b0;
                            state_reg   <= S_WAIT_RDY;
`ifdef TAG_TX_WHITEN_EN
                            lfsr_reg    <= 9'h1FF;
`endif
                        end
                    end
                    S_WAIT_RDY: begin
                        if (tag_rdy) begin
                            state_reg    <= S_SYNC;
                            sync_reg     <= 1'b1;
                            hop_rst_reg  <= 1'b1;
                            sync_cnt_reg <= '0;
                        end
                    end
                    S_SYNC: begin
                        if (sync_cnt_reg == SYNC_W'(SYNC_SIG_N - 1)) begin
                            state_reg   <= S_HOP;
                            sync_reg    <= 1'b0;
                            hop_rst_reg <= 1'b0;
                            hop_clk_reg <= 1'b1;
                            nhop_reg    <= '0;
                        end else begin
                            sync_cnt_reg <= sync_cnt_reg + 1'b1;
                        end
                    end
                    S_HOP: begin
                        state_reg    <= S_DATA;
                        bit_cnt_reg  <= '0;
                        samp_cnt_reg <= '0;
                        tx_valid_reg <= 1'b1;
                        itx_reg      <= first_bit ? AMP_POS : AMP_NEG;
                        tx_bit_reg   <= first_bit;
                    end
                    S_DATA: begin
                        if (samp_cnt_reg == SAMP_W'(SAMPS_PER_BIT - 1)) begin
                            samp_cnt_reg <= '0;
                            payload_reg  <= payload_reg << 1;
`ifdef TAG_TX_WHITEN_EN
                            lfsr_reg     <= {lfsr_reg[7:0], lfsr_reg[8] ^ lfsr_reg[4]};
`endif
                            if (bit_cnt_reg == BIT_CNT_WIDTH'(BITS_PER_HOP - 1)) begin
                                tx_valid_reg <= 1'b0;
                                itx_reg      <= '0;
                                tx_bit_reg   <= 1'b0;
                                if (nhop_reg == BIT_CNT_WIDTH'(NUM_HOPS - 1)) begin
                                    state_reg   <= S_DONE;
                                    tx_done_reg <= 1'b1;
                                end else begin
                                    state_reg   <= S_HOP;
                                    nhop_reg    <= nhop_reg + 1'b1;
                                    hop_clk_reg <= 1'b1;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                                itx_reg     <= next_bit ? AMP_POS : AMP_NEG;
                                tx_bit_reg  <= next_bit;
                            end
                        end else begin
                            samp_cnt_reg <= samp_cnt_reg + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_reg <= S_IDLE;
                        ready_reg <= tag_en;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < GPIO_REG_WIDTH; gi++) begin : g_gpio
            if (gi == 8) begin : g_sync
                assign fp_gpio_out[gi] = sync_reg;
            end else if (gi == 9) begin : g_hclk
                assign fp_gpio_out[gi] = hop_clk_reg;
            end else if (gi == 10) begin : g_hrst
                assign fp_gpio_out[gi] = hop_rst_reg;
            end else if (gi == 11) begin : g_bit
                assign fp_gpio_out[gi] = tx_bit_reg;
            end else begin : g_zero
                assign fp_gpio_out[gi] = 1'b0;
            end
        end
    endgenerate

    assign fp_gpio_ddr   = ddr_reg;
    assign payload_ready = ready_reg;
    assign itx_out       = itx_reg;
    assign qtx_out       = '0;
    assign tx_valid      = tx_valid_reg;
    assign tx_state      = state_reg;
    assign hop_rst       = hop_rst_reg;
    assign hop_clk       = hop_clk_reg;
    assign nhop          = nhop_reg;
    assign ntx_bits_cnt  = bit_cnt_reg;
    assign tx_done       = tx_done_reg;

endmodule
